// File: rtl/pipe_stage_ctrl_if.sv
// Handshake/status bundle between pipe_stage_ctrl and its producer/consumer environment.
// PIPE_PERF_EN adds the StallCount status signal.
interface pipe_stage_ctrl_if #(
   parameter int unsigned STAGES = 4,
   parameter int unsigned CNT_W  = 16
);
   localparam int unsigned OCC_W = $clog2(STAGES + 1);

   logic              Start;
   logic              Flush;
   logic              InValid;
   logic              InLast;
   logic              InReady;
   logic              OutValid;
   logic              OutReady;
   logic [STAGES-1:0] StageEn;
   logic [STAGES-1:0] StageValid;
   logic [OCC_W-1:0]  Occupancy;
   logic [CNT_W-1:0]  BeatCount;
   logic              Busy;
   logic              Done;
`ifdef PIPE_PERF_EN
   logic [CNT_W-1:0]  StallCount;

   modport master (
      output Start, Flush, InValid, InLast, OutReady,
      input  InReady, OutValid, StageEn, StageValid, Occupancy, BeatCount, Busy, Done,
      input  StallCount
   );

   modport slave (
      input  Start, Flush, InValid, InLast, OutReady,
      output InReady, OutValid, StageEn, StageValid, Occupancy, BeatCount, Busy, Done,
      output StallCount
   );
`else
   modport master (
      output Start, Flush, InValid, InLast, OutReady,
      input  InReady, OutValid, StageEn, StageValid, Occupancy, BeatCount, Busy, Done
   );

   modport slave (
      input  Start, Flush, InValid, InLast, OutReady,
      output InReady, OutValid, StageEn, StageValid, Occupancy, BeatCount, Busy, Done
   );
`endif
endinterface

// File: rtl/pipe_stage_ctrl.sv
// Load-enable / valid sequencing for a chain of STAGES register banks with bubble collapse,
// backpressure and Start/InLast/Done framing. Optional stall counter under PIPE_PERF_EN.
module pipe_stage_ctrl #(
   parameter int unsigned STAGES = 4,
   parameter int unsigned CNT_W  = 16
) (
   input logic              Clk,
   input logic              Rst_n,
   pipe_stage_ctrl_if.slave bus
);
   localparam int unsigned OCC_W = $clog2(STAGES + 1);
   localparam logic [OCC_W-1:0] OccOne = OCC_W'(1);
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e            state_q, state_d;
   logic [STAGES-1:0] valid_q, valid_d;
   logic [STAGES-1:0] en;
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic [CNT_W-1:0]  beat_q, beat_d;
   logic              done_q, done_d;
   logic              run;
   logic              in_ready;
   logic              accept;
   logic              out_hs;

   // A stage may load when it is empty or the stage after it is itself loading.
   always_comb begin
      logic chain;
      chain = bus.OutReady;
      en    = '0;
      for (int i = STAGES - 1; i >= 0; i--) begin
         chain = !valid_q[i] | chain;
         en[i] = chain;
      end
   end

   assign run      = (state_q == StRun);
   assign in_ready = en[0] & run;
   assign accept   = bus.InValid & in_ready;
   assign out_hs   = valid_q[STAGES-1] & bus.OutReady;

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      occ_d   = occ_q;
      beat_d  = beat_q;
      done_d  = 1'b0;

      // Stage 0 follows en[0] in every state so that its beat is not duplicated while draining;
      // outside RUN it can only load a bubble.
      if (en[0]) begin
         valid_d[0] = accept;
      end
      for (int i = 1; i < STAGES; i++) begin
         if (en[i]) begin
            valid_d[i] = valid_q[i-1];
         end
      end

      unique case ({accept, out_hs})
         2'b10:   occ_d = occ_q + OccOne;
         2'b01:   occ_d = occ_q - OccOne;
         default: occ_d = occ_q;
      endcase

      if (bus.Flush) begin
         state_d = StIdle;
         valid_d = '0;
         occ_d   = '0;
         beat_d  = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.Start) begin
                  state_d = StRun;
                  beat_d  = '0;
               end
            end
            StRun: begin
               if (accept) begin
                  beat_d = beat_q + CntOne;
                  if (bus.InLast) begin
                     state_d = StDrain;
                  end
               end
            end
            StDrain: begin
               if (occ_d == '0) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q <= StIdle;
         valid_q <= '0;
         occ_q   <= '0;
         beat_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         occ_q   <= occ_d;
         beat_q  <= beat_d;
         done_q  <= done_d;
      end
   end

   assign bus.InReady    = in_ready;
   assign bus.OutValid   = valid_q[STAGES-1];
   assign bus.StageEn    = {en[STAGES-1:1], in_ready};
   assign bus.StageValid = valid_q;
   assign bus.Occupancy  = occ_q;
   assign bus.BeatCount  = beat_q;
   assign bus.Busy       = (state_q != StIdle);
   assign bus.Done       = done_q;

`ifdef PIPE_PERF_EN
   logic [CNT_W-1:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (bus.Flush || (state_q == StIdle && bus.Start)) begin
         stall_d = '0;
      end else if (valid_q[STAGES-1] && !bus.OutReady && (stall_q != '1)) begin
         stall_d = stall_q + CntOne;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign bus.StallCount = stall_q;
`endif
endmodule
